// File: rtl/wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_pkg : shared widths and queue entry type for the write-back path  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package wb_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam int NUM_REGS   = 32;
   localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]     data;
   } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/regfile_writeback_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_writeback_if : ALU / mul-div result and reg-file write bus   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface regfile_writeback_if #(
   parameter int DEPTH = 4
);
   import wb_pkg::*;

   logic                       AluValid;
   logic [REG_ADDR_W-1:0]      AluAddr;
   logic [DATA_W-1:0]          AluData;
   logic                       MdValid;
   logic                       MdReady;
   logic [REG_ADDR_W-1:0]      MdAddr;
   logic [DATA_W-1:0]          MdData;
   logic [REG_ADDR_W-1:0]      WriteAddr;
   logic [DATA_W-1:0]          WriteData;
   logic                       RegWrite;
   logic [NUM_REGS-1:0]        Pending;
   logic [$clog2(DEPTH):0]     Count;

   modport master (
      output AluValid, AluAddr, AluData, MdValid, MdAddr, MdData,
      input  MdReady, WriteAddr, WriteData, RegWrite, Pending, Count
   );

   modport slave (
      input  AluValid, AluAddr, AluData, MdValid, MdAddr, MdData,
      output MdReady, WriteAddr, WriteData, RegWrite, Pending, Count
   );

endinterface
`default_nettype wire

// File: rtl/wb_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_queue : in-order mul/div result queue with per-address cancel     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wb_queue
   import wb_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  wire logic                  Clock,
   input  wire logic                  Reset,
   input  wire logic                  i_push,
   input  wire wb_entry_t             i_push_entry,
   input  wire logic                  i_pop,
   input  wire logic                  i_cancel_en,
   input  wire logic [REG_ADDR_W-1:0] i_cancel_addr,
   output wb_entry_t                  o_head,
   output logic [CNT_W-1:0]           o_count,
   output logic [NUM_REGS-1:0]        o_pending
);

   wb_entry_t          r_mem [DEPTH];
   logic [PTR_W-1:0]   r_rd;
   logic [PTR_W-1:0]   r_wr;
   logic [CNT_W-1:0]   r_count;
   logic [NUM_REGS-1:0] w_pending;

   // The push write comes last so a same-cycle entry is never cancelled.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i_cancel_en && r_mem[i].valid && (r_mem[i].addr == i_cancel_addr))
               r_mem[i].valid <= 1'b0;
         end
         if (i_pop) begin
            r_mem[r_rd].valid <= 1'b0;
            r_rd              <= r_rd + PTR_W'(1);
         end
         if (i_push) begin
            r_mem[r_wr] <= i_push_entry;
            r_wr        <= r_wr + PTR_W'(1);
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_comb begin
      w_pending = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_mem[i].valid) w_pending[r_mem[i].addr] = 1'b1;
      end
      w_pending[0] = 1'b0;
   end

   assign o_head    = r_mem[r_rd];
   assign o_count   = r_count;
   assign o_pending = w_pending;

endmodule
`default_nettype wire

// File: rtl/regfile_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_writeback : arbitrates ALU and queued mul/div results into   |
// | one registered register-file write per cycle.  Rev 1.0               |
// +----------------------------------------------------------------------+
module regfile_writeback
   import wb_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  wire logic         Clock,
   input  wire logic         Reset,
   regfile_writeback_if.slave bus
);

   wb_entry_t               w_head;
   wb_entry_t               w_push_entry;
   logic [CNT_W-1:0]        w_count;
   logic [NUM_REGS-1:0]     w_pending;
   logic                    w_alu_act;
   logic                    w_pop;
   logic                    w_head_wr;
   logic                    w_md_ready;
   logic                    w_push;

   logic                    r_reg_write;
   logic [REG_ADDR_W-1:0]   r_write_addr;
   logic [DATA_W-1:0]       r_write_data;

   // A write to r0 is treated as no ALU result at all, letting the queue drain.
   assign w_alu_act  = bus.AluValid && (bus.AluAddr != ZERO_REG);
   assign w_pop      = !w_alu_act && (w_count != '0);
   assign w_head_wr  = w_pop && w_head.valid;
   assign w_md_ready = !Reset && (w_count < CNT_W'(DEPTH));
   assign w_push     = bus.MdValid && w_md_ready && (bus.MdAddr != ZERO_REG);

   assign w_push_entry = '{valid: 1'b1, addr: bus.MdAddr, data: bus.MdData};

   wb_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .Clock         (Clock),
      .Reset         (Reset),
      .i_push        (w_push),
      .i_push_entry  (w_push_entry),
      .i_pop         (w_pop),
      .i_cancel_en   (w_alu_act),
      .i_cancel_addr (bus.AluAddr),
      .o_head        (w_head),
      .o_count       (w_count),
      .o_pending     (w_pending)
   );

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_reg_write  <= 1'b0;
         r_write_addr <= '0;
         r_write_data <= '0;
      end else begin
         r_reg_write <= w_alu_act || w_head_wr;
         if (w_alu_act) begin
            r_write_addr <= bus.AluAddr;
            r_write_data <= bus.AluData;
         end else if (w_head_wr) begin
            r_write_addr <= w_head.addr;
            r_write_data <= w_head.data;
         end
      end
   end

   assign bus.MdReady   = w_md_ready;
   assign bus.RegWrite  = r_reg_write;
   assign bus.WriteAddr = r_write_addr;
   assign bus.WriteData = r_write_data;
   assign bus.Pending   = w_pending;
   assign bus.Count     = w_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_regfile_writeback : directed stimulus with write scoreboard       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_regfile_writeback;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } exp_t;

   logic Clock = 1'b0;
   logic Reset = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;
   exp_t sb[$];

   regfile_writeback_if #(.DEPTH(4)) bus ();

   regfile_writeback #(.DEPTH(4)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clock = ~Clock;

   // Monitor: every write the DUT presents must match the oldest expectation.
   always @(negedge Clock) begin
      if (bus.RegWrite === 1'b1) begin
         n_chk++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL write_unexpected actual addr=%0d data=%h required none",
                     bus.WriteAddr, bus.WriteData);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (bus.WriteAddr !== e.a || bus.WriteData !== e.d) begin
               n_err++;
               $display("FAIL write_value actual addr=%0d data=%h required addr=%0d data=%h",
                        bus.WriteAddr, bus.WriteData, e.a, e.d);
            end
         end
      end
   end

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.AluValid = 1'b0; bus.AluAddr = '0; bus.AluData = '0;
      bus.MdValid  = 1'b0; bus.MdAddr  = '0; bus.MdData  = '0;
   endtask

   task automatic alu(input logic [4:0] a, input logic [31:0] d, input bit exp_write);
      bus.AluValid = 1'b1; bus.AluAddr = a; bus.AluData = d;
      if (exp_write) sb.push_back('{a: a, d: d});
   endtask

   task automatic md(input logic [4:0] a, input logic [31:0] d);
      bus.MdValid = 1'b1; bus.MdAddr = a; bus.MdData = d;
   endtask

   initial begin
      idle_inputs();
      repeat (3) step();
      chk_eq("rst_regwrite",  32'(bus.RegWrite),  32'h0);
      chk_eq("rst_waddr",     32'(bus.WriteAddr), 32'h0);
      chk_eq("rst_wdata",     bus.WriteData,      32'h0);
      chk_eq("rst_count",     32'(bus.Count),     32'h0);
      chk_eq("rst_pending",   bus.Pending,        32'h0);
      chk_eq("rst_mdready",   32'(bus.MdReady),   32'h0);
      Reset = 1'b0;
      #1;
      chk_eq("post_rst_mdready", 32'(bus.MdReady), 32'h1);

      // ALU single-cycle write
      alu(5'd3, 32'hDEADBEEF, 1'b1);
      step();
      chk_eq("alu_regwrite", 32'(bus.RegWrite), 32'h1);
      idle_inputs();
      step();
      chk_eq("alu_regwrite_drop", 32'(bus.RegWrite), 32'h0);

      // Mul/div through the queue, two-edge latency
      md(5'd5, 32'h12345678);
      sb.push_back('{a: 5'd5, d: 32'h12345678});
      step();
      chk_eq("md_count1",   32'(bus.Count), 32'h1);
      chk_eq("md_pending5", bus.Pending,    32'h0000_0020);
      chk_eq("md_no_write_yet", 32'(bus.RegWrite), 32'h0);
      idle_inputs();
      step();
      chk_eq("md_regwrite", 32'(bus.RegWrite), 32'h1);
      chk_eq("md_count0",   32'(bus.Count),    32'h0);
      chk_eq("md_pending0", bus.Pending,       32'h0);

      // Starvation and backpressure: ALU blocks draining until queue is full
      for (int k = 0; k < 4; k++) begin
         alu(5'd1, 32'h100 + k, 1'b1);
         md(5'(8 + k), 32'h800 + k);
         step();
      end
      chk_eq("full_count",   32'(bus.Count),   32'h4);
      chk_eq("full_mdready", 32'(bus.MdReady), 32'h0);
      chk_eq("full_pending", bus.Pending,      32'h0000_0F00);
      alu(5'd1, 32'h104, 1'b1);
      md(5'd12, 32'hC);
      step();
      chk_eq("full_held_count", 32'(bus.Count), 32'h4);
      bus.AluValid = 1'b0;
      for (int k = 0; k < 5; k++) sb.push_back('{a: 5'(8 + k), d: (k < 4) ? 32'h800 + k : 32'hC});
      step();
      chk_eq("drain1_count",   32'(bus.Count),   32'h3);
      chk_eq("drain1_mdready", 32'(bus.MdReady), 32'h1);
      step();
      chk_eq("drain_enq_deq_count", 32'(bus.Count), 32'h3);
      idle_inputs();
      repeat (3) begin
         chk_eq("drain_consecutive", 32'(bus.RegWrite), 32'h1);
         step();
      end
      chk_eq("drain_done_count", 32'(bus.Count), 32'h0);
      chk_eq("drain_done_pend",  bus.Pending,    32'h0);

      // WAW cancel: younger ALU write kills queued entry to same register
      md(5'd7, 32'hAAAA);
      step();
      idle_inputs();
      alu(5'd7, 32'hBBBB, 1'b1);
      step();
      chk_eq("waw_pending", bus.Pending,    32'h0);
      chk_eq("waw_count",   32'(bus.Count), 32'h1);
      idle_inputs();
      step();
      chk_eq("waw_cancel_nowrite", 32'(bus.RegWrite), 32'h0);
      chk_eq("waw_cancel_count",   32'(bus.Count),    32'h0);
      step();
      chk_eq("waw_quiet", 32'(bus.RegWrite), 32'h0);

      // Register zero is ignored on both paths
      alu(5'd0, 32'h1111, 1'b0);
      step();
      chk_eq("alu_r0_nowrite", 32'(bus.RegWrite), 32'h0);
      idle_inputs();
      md(5'd0, 32'h55);
      step();
      chk_eq("md_r0_count",   32'(bus.Count),   32'h0);
      chk_eq("md_r0_mdready", 32'(bus.MdReady), 32'h1);
      chk_eq("md_r0_nowrite", 32'(bus.RegWrite), 32'h0);
      idle_inputs();

      // Same-cycle ALU and MD to one register: MD is younger and survives
      alu(5'd9, 32'h99, 1'b1);
      md(5'd9, 32'h9A);
      sb.push_back('{a: 5'd9, d: 32'h9A});
      step();
      chk_eq("same_cycle_pending", bus.Pending, 32'h0000_0200);
      idle_inputs();
      step();
      step();

      // Asynchronous reset with three entries queued
      for (int k = 0; k < 3; k++) begin
         alu(5'd2, 32'h200 + k, 1'b1);
         md(5'(20 + k), 32'h2000 + k);
         step();
      end
      idle_inputs();
      chk_eq("pre_rst_count", 32'(bus.Count), 32'h3);
      @(negedge Clock);
      #1;
      Reset = 1'b1;
      #1;
      chk_eq("async_rst_count",   32'(bus.Count),     32'h0);
      chk_eq("async_rst_pending", bus.Pending,        32'h0);
      chk_eq("async_rst_regwr",   32'(bus.RegWrite),  32'h0);
      chk_eq("async_rst_waddr",   32'(bus.WriteAddr), 32'h0);
      chk_eq("async_rst_wdata",   bus.WriteData,      32'h0);
      step();
      step();
      Reset = 1'b0;
      repeat (4) begin
         step();
         chk_eq("post_rst_nowrite", 32'(bus.RegWrite), 32'h0);
      end

      chk_eq("scoreboard_empty", 32'(sb.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/regfile_writeback.md
# regfile_writeback

Write-port driver for the 32×32 register file. Merges results from the single-cycle ALU path and the long-latency multiply/divide unit into one registered write per cycle on WriteAddr/WriteData/RegWrite. Multiply/divide results wait in a small in-order queue. ALU results bypass the queue and cancel older queued writes to the same register, which preserves write-after-write order. Sits between execute and the register file, and exports a pending-write mask for hazard detection.

## Interface
- DEPTH, 4, queue entries for multiply/divide results; power of 2, ≥2
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high
- AluValid  in  1  ALU result present this cycle; always accepted, no backpressure
- AluAddr  in  5  ALU destination register
- AluData  in  32  ALU result
- MdValid  in  1  mul/div result offered
- MdReady  out  1  queue can accept; transfer occurs when MdValid && MdReady
- MdAddr  in  5  mul/div destination register
- MdData  in  32  mul/div result
- WriteAddr  out  5  register-file write address (registered)
- WriteData  out  32  register-file write data (registered)
- RegWrite  out  1  register-file write enable (registered)
- Pending  out  32  bit i = 1 iff a valid queued entry targets register i; bit 0 is always 0
- Count  out  $clog2(DEPTH)+1  occupied queue slots, including cancelled slots

## Operation
- Queue entry fields: valid, addr[4:0], data[31:0]. Entries are in FIFO order.
- Enqueue:
  - Happens on MdValid && MdReady.
  - MdReady = !Reset && (Count < DEPTH). There is no enqueue-through-dequeue when full.
  - MdAddr == 0 is accepted and discarded. Count does not change.
- Output selection, evaluated each cycle and registered at the edge:
  - Priority 1, AluValid && AluAddr != 0: present the ALU result. The queue head is not popped.
  - Priority 2, queue non-empty and head valid: present the head entry and pop it.
  - Priority 3, queue non-empty and head cancelled: pop it and write nothing (RegWrite = 0).
  - Otherwise RegWrite = 0. WriteAddr and WriteData hold their previous values.
- AluValid with AluAddr == 0 writes nothing and counts as absent, so the queue may drain that cycle.
- WAW cancel:
  - An accepted ALU write to X != 0 clears valid on every entry already queued with addr X.
  - An MD entry to X enqueued in the same cycle is NOT cancelled. It is treated as younger and is written later.
- Pending is combinational from the queue's valid/addr fields.
- Starvation: continuous ALU writes block draining. Backpressure reaches the mul/div unit through MdReady.

## Timing
- Reset values: RegWrite = 0, WriteAddr = 0, WriteData = 0, Count = 0, Pending = 0, MdReady = 0 while Reset is high. All queue entries are invalid.
- Reset mid-operation flushes the queue immediately, asynchronously. Queued writes are lost.
- ALU latency: AluValid sampled at edge n gives RegWrite = 1 after edge n.
- Mul/div minimum latency is 2 edges: enqueue at edge n, then RegWrite after edge n+1 if no ALU write competes.
- Simultaneous enqueue and dequeue: Count is unchanged, and the entry is appended behind the remaining entries.
- Pointer wrap-around: read and write pointers are modulo DEPTH. Full/empty comes from Count.
- Cancelled entries keep their slot until popped. They still hold MdReady low when the queue is full.

## Structure
- Package wb_pkg holds:
  - REG_ADDR_W = 5, DATA_W = 32, NUM_REGS = 32, ZERO_REG = 5'd0.
  - Packed struct wb_entry_t {valid, addr, data}.
- Sub-module wb_queue owns the queue:
  - Signals: push, pop, head, count, per-entry cancel by address, pending mask.
  - Top level holds only the arbitration and output registers.
- Target size: roughly 150–250 lines total.

## Test plan
- Reset, then ALU addr 3 data 0xDEADBEEF for one cycle → next cycle RegWrite = 1, WriteAddr = 3, WriteData = 0xDEADBEEF; cycle after that RegWrite = 0.
- MD addr 5 data 0x12345678, ALU idle → Count = 1 and Pending[5] = 1 after edge 1; RegWrite = 1, addr 5, data 0x12345678 after edge 2; Pending = 0.
- ALU writes addr 1 every cycle while 4 MD entries are pushed (addr 8–11) → after the 4th push Count = 4, MdReady = 0, and a 5th MD offer waits. Stop ALU → writes appear to 8, 9, 10, 11 on 4 consecutive cycles, then the held 5th entry.
- Queue holds addr 7 data 0xAAAA, then ALU addr 7 data 0xBBBB → RegWrite writes 0xBBBB to 7 and Pending[7] clears. The next cycle pops the cancelled slot with RegWrite = 0, and 0xAAAA is never written.
- ALU addr 0, then MD addr 0 → RegWrite stays 0, Count stays 0, MdReady stays 1.
- Reset asserted with Count = 3, between edges → Count, Pending, RegWrite, WriteAddr, WriteData all 0 immediately. No write occurs after release.
